// File: rtl/osd_window_pipe.sv
// osd_window_pipe: SCALE-replicated region image overlaid on a window of the pixel stream (OSD_BLEND_EN: 50% blend).
// Fixed RD_LAT+1 cycle latency on sync and data, one pixel per clock, no backpressure.
module osd_window_pipe #(
  parameter logic [11:0] X0     = 12'd650,
  parameter logic [11:0] Y0     = 12'd362,
  parameter int          WIN_W  = 256,
  parameter int          WIN_H  = 256,
  parameter int          SCALE  = 1,
  parameter int          RD_LAT = 1,
  parameter int          DW     = 8,
  parameter int          ADDR_W = 16
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              i_hs,
  input  logic              i_vs,
  input  logic              i_de,
  input  logic [23:0]       i_data,
  output logic              o_ram_rd_en,
  output logic [ADDR_W-1:0] o_ram_addr,
  input  logic [DW-1:0]     i_region_data,
  output logic              o_frame_start,
  output logic              o_hs,
  output logic              o_vs,
  output logic              o_de,
  output logic [23:0]       o_data
);

  localparam int COLS = WIN_W / SCALE;
  localparam int SW   = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int XL   = int'(X0);
  localparam int XH   = XL + WIN_W - 1;
  localparam int YL   = int'(Y0);
  localparam int YH   = YL + WIN_H - 1;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        hit;
    logic [23:0] data;
  } stage_t;

  logic              de_d1_q, vs_d1_q;
  logic              y_ok_q, y_ok_d;
  logic [11:0]       x_q, x_d, y_q, y_d;
  logic [SW-1:0]     sub_x_q, sub_x_d, sub_y_q, sub_y_d;
  logic [ADDR_W-1:0] col_q, col_d, row_base_q, row_base_d, addr_q, addr_d;
  logic              rd_en_q, fs_q, hs_q, vs_q, de_q;
  logic [23:0]       data_q, data_d;
  stage_t            stage_q [RD_LAT];
  stage_t            tail;
  logic              de_fall, vs_rise, vs_fall, x_in, y_in, hit;
  logic [23:0]       region_rgb, mix;

  assign de_fall = de_d1_q & ~i_de;
  assign vs_rise = ~vs_d1_q & i_vs;
  assign vs_fall = vs_d1_q & ~i_vs;
  assign x_in    = (int'(x_q) >= XL) && (int'(x_q) <= XH);
  assign y_in    = (int'(y_q) >= YL) && (int'(y_q) <= YH);
  // y_ok_q stays low after reset so a half-counted frame never opens the window.
  assign hit     = i_de & y_ok_q & x_in & y_in;

  always_comb begin
    x_d    = i_de ? x_q + 12'd1 : 12'd0;
    y_d    = y_q;
    y_ok_d = y_ok_q;
    if (vs_rise) begin
      y_d    = 12'd0;
      y_ok_d = 1'b1;
    end else if (de_fall) begin
      y_d = y_q + 12'd1;
    end
  end

  always_comb begin
    sub_x_d    = sub_x_q;
    col_d      = col_q;
    sub_y_d    = sub_y_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    if (fs_q) begin
      sub_x_d    = '0;
      col_d      = '0;
      sub_y_d    = '0;
      row_base_d = '0;
    end else if (hit) begin
      addr_d = row_base_q + col_q;
      if (sub_x_q == SW'(SCALE - 1)) begin
        sub_x_d = '0;
        col_d   = col_q + ADDR_W'(1);
      end else begin
        sub_x_d = sub_x_q + SW'(1);
      end
    end else if (rd_en_q) begin
      // End of a hit run: one displayed window line done, clipped or not.
      sub_x_d = '0;
      col_d   = '0;
      if (sub_y_q == SW'(SCALE - 1)) begin
        sub_y_d    = '0;
        row_base_d = row_base_q + ADDR_W'(COLS);
      end else begin
        sub_y_d = sub_y_q + SW'(1);
      end
    end
  end

  assign tail = stage_q[RD_LAT-1];

  if (DW == 24) begin : g_rgb
    assign region_rgb = i_region_data;
  end else begin : g_gray
    assign region_rgb = {3{i_region_data[7:0]}};
  end

`ifdef OSD_BLEND_EN
  for (genvar k = 0; k < 3; k++) begin : g_blend
    assign mix[8*k +: 8] = 8'(({1'b0, region_rgb[8*k +: 8]} + {1'b0, tail.data[8*k +: 8]}) >> 1);
  end
`else
  assign mix = region_rgb;
`endif

  assign data_d = tail.hit ? mix : tail.data;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      de_d1_q    <= 1'b0;
      vs_d1_q    <= 1'b0;
      y_ok_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      sub_x_q    <= '0;
      col_q      <= '0;
      sub_y_q    <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      fs_q       <= 1'b0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      de_q       <= 1'b0;
      data_q     <= '0;
      for (int k = 0; k < RD_LAT; k++) stage_q[k] <= '0;
    end else begin
      de_d1_q    <= i_de;
      vs_d1_q    <= i_vs;
      y_ok_q     <= y_ok_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sub_x_q    <= sub_x_d;
      col_q      <= col_d;
      sub_y_q    <= sub_y_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      rd_en_q    <= hit;
      fs_q       <= vs_fall;
      stage_q[0] <= '{hs: i_hs, vs: i_vs, de: i_de, hit: hit, data: i_data};
      for (int k = 1; k < RD_LAT; k++) stage_q[k] <= stage_q[k-1];
      hs_q       <= tail.hs;
      vs_q       <= tail.vs;
      de_q       <= tail.de;
      data_q     <= data_d;
    end
  end

  assign o_ram_rd_en   = rd_en_q;
  assign o_ram_addr    = addr_q;
  assign o_frame_start = fs_q;
  assign o_hs          = hs_q;
  assign o_vs          = vs_q;
  assign o_de          = de_q;
  assign o_data        = data_q;

endmodule
